symbol_scheduler: RTL and testbench
===================================

// Module: symbol_scheduler
// PURPOSE
//  Feeds stage_1 of the AV1 arithmetic-encoder pipeline from N_REQ symbol sources (tiles/streams).
//  One source owns the pipeline until its end-of-stream beat, because range state must not interleave.
//  Per stream: round-robin grant, 1-cycle registered issue, drain, pipeline flush, wait for flush ack.
// PARAMETERS
//  N_REQ        2   number of requesters (>=2)
//  ID_WIDTH     1   owner index width, = clog2(N_REQ)
//  RANGE_WIDTH  16  FL/FH width
//  SYMBOL_WIDTH 4   symbol width; NSYMS is SYMBOL_WIDTH+1
//  PIPE_DEPTH   4   non-stalled cycles for the last symbol to leave the pipeline (>=1)
// PORTS
//  clk_scheduler  in   1                   single clock, rising edge
//  reset          in   1                   synchronous, active-low
//  req_valid      in   N_REQ               per-requester beat valid
//  req_last       in   N_REQ               beat is last of stream
//  req_fl/req_fh  in   N_REQ*RANGE_WIDTH   packed, requester i at [i*RW +: RW]
//  req_symbol     in   N_REQ*SYMBOL_WIDTH  packed
//  req_nsyms      in   N_REQ*(SYMBOL_WIDTH+1) packed
//  req_bool       in   N_REQ               packed
//  req_ready      out  N_REQ               beat accepted when valid&ready
//  out_valid      out  1                   beat valid to stage_1
//  FL, FH         out  RANGE_WIDTH         to stage_1
//  SYMBOL         out  SYMBOL_WIDTH        to stage_1
//  NSYMS          out  SYMBOL_WIDTH+1      to stage_1
//  bool           out  1                   to stage_1
//  pipe_stall     in   1                   downstream backpressure; pipeline frozen
//  pipe_flush     out  1                   one-cycle flush command to final stage
//  flush_ack      in   1                   final stage finished flushing
//  owner_id       out  ID_WIDTH            current owner (valid when busy)
//  busy           out  1                   state != IDLE
//  err            out  1                   sticky parameter error (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, all outputs 0, rr_ptr=0, drain_cnt=0, err=0. Mid-stream reset abandons the stream; no flush is issued.
//  FSM IDLE->RUN->DRAIN->FLUSH->WAIT_ACK->IDLE.
//  IDLE: grant the first i with req_valid[i], scanning from rr_ptr upward with wrap; owner_id<=i, ->RUN next cycle. No beat is accepted in IDLE.
//  RUN: req_ready[i] = (i==owner_id) & ~pipe_stall; all other requesters get 0.
//   Accepted beat is registered onto outputs with out_valid=1 the next cycle (latency 1).
//   Cycle without an accepted beat and ~pipe_stall: out_valid<=0. pipe_stall=1: all outputs hold.
//   Accepted beat with req_last=1: ->DRAIN, drain_cnt<=0. The last beat is still issued.
//  DRAIN: req_ready=0. drain_cnt increments on each ~pipe_stall cycle; at drain_cnt==PIPE_DEPTH-1 with ~pipe_stall ->FLUSH.
//  FLUSH: pipe_flush=1 for exactly one cycle in which pipe_stall==0; while stalled, wait in FLUSH with pipe_flush=0. Then ->WAIT_ACK.
//  WAIT_ACK: on flush_ack=1 ->IDLE, rr_ptr<=owner_id+1 (wraps at N_REQ). flush_ack in any other state is ignored.
//  Width rules: NSYMS passed unmodified; no arithmetic on FL/FH. rr_ptr wrap at N_REQ when it is not a power of 2.
//  Simultaneous: req_valid from a non-owner during RUN is held off (ready=0), no starvation beyond one stream.
// CONFIGURATION
//  SCHED_PARAM_CHECK_EN defined: accepted beat is checked with NSYMS==0 | NSYMS>2**SYMBOL_WIDTH | (~req_bool & SYMBOL>=NSYMS).
//   Failing beat: consumed (ready as normal), not issued (out_valid<=0), err<=1 sticky until reset; its req_last is still honoured.
//  Not defined: no check, every beat forwarded, err tied 0.
// STRUCTURE
//  Package sched_pkg: state enum (IDLE,RUN,DRAIN,FLUSH,WAIT_ACK), default widths, clog2 helper.
//  Sub-module rr_arbiter (N_REQ req, rr_ptr in -> one-hot grant + index out), purely combinational.
//  FSM, operand mux (indexed by owner_id), output register and drain counter live in symbol_scheduler.
// TESTING
//  1 Req0 sends 3 beats (FL=0x8000,FH=0x7F00,sym 2,nsyms 4), last on 3rd -> 3 out_valid pulses 1 cycle after each accept, owner_id=0, then PIPE_DEPTH cycles later one pipe_flush pulse.
//  2 Both requesters valid in IDLE after reset -> req0 granted; after flush_ack, req1 granted (rr_ptr=1); req1 ready stays 0 throughout req0's stream.
//  3 pipe_stall=1 for 5 cycles mid-RUN -> req_ready=0, outputs frozen; in DRAIN the stall adds 5 cycles to the flush time; pipe_flush is not asserted while stalled.
//  4 flush_ack pulsed during RUN -> ignored; withheld 10 cycles in WAIT_ACK -> busy stays 1, no new grant.
//  5 reset=0 during DRAIN -> next cycle all outputs 0, state IDLE, no pipe_flush.
//  6 (SCHED_PARAM_CHECK_EN) beat nsyms=3, sym=5, bool=0, last=1 -> not issued, err=1, DRAIN/FLUSH still run; without the macro the beat is issued, err=0.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and defaults for the symbol scheduler: FSM state encoding,
// default parameter values and a constant-evaluable clog2 helper.
package sched_pkg;

    localparam int DEF_N_REQ        = 2;
    localparam int DEF_ID_WIDTH     = 1;
    localparam int DEF_RANGE_WIDTH  = 16;
    localparam int DEF_SYMBOL_WIDTH = 4;
    localparam int DEF_PIPE_DEPTH   = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        DRAIN    = 3'd2,
        FLUSH    = 3'd3,
        WAIT_ACK = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or above
// rr_ptr (with wrap at N_REQ) and returns it as one-hot and as an index.
module rr_arbiter
    import sched_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int ID_WIDTH = DEF_ID_WIDTH
) (
    input  logic [N_REQ-1:0]    req,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic [N_REQ-1:0]    grant,
    output logic [ID_WIDTH-1:0] grant_idx
);

    always_comb begin
        int slot;
        // NOTE: every output gets a default before the search loop, so no path leaves one unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        slot      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            slot = int'(rr_ptr) + k;
            if (slot >= N_REQ) begin
                slot = slot - N_REQ;
            end
            if (grant == '0 && req[slot[ID_WIDTH-1:0]]) begin
                grant     = N_REQ'(1) << slot;
                grant_idx = ID_WIDTH'(slot);
            end
        end
    end

endmodule

// File: rtl/symbol_scheduler.sv
// Stream-granular scheduler feeding stage_1 of the arithmetic encoder.
// Optional beat parameter checking is enabled with `define SCHED_PARAM_CHECK_EN.
module symbol_scheduler
    import sched_pkg::*;
#(
    parameter int N_REQ        = DEF_N_REQ,
    parameter int ID_WIDTH     = DEF_ID_WIDTH,
    parameter int RANGE_WIDTH  = DEF_RANGE_WIDTH,
    parameter int SYMBOL_WIDTH = DEF_SYMBOL_WIDTH,
    parameter int PIPE_DEPTH   = DEF_PIPE_DEPTH
) (
    input  logic                                clk_scheduler,
    input  logic                                reset,
    input  logic [N_REQ-1:0]                    req_valid,
    input  logic [N_REQ-1:0]                    req_last,
    input  logic [N_REQ*RANGE_WIDTH-1:0]        req_fl,
    input  logic [N_REQ*RANGE_WIDTH-1:0]        req_fh,
    input  logic [N_REQ*SYMBOL_WIDTH-1:0]       req_symbol,
    input  logic [N_REQ*(SYMBOL_WIDTH+1)-1:0]   req_nsyms,
    input  logic [N_REQ-1:0]                    req_bool,
    output logic [N_REQ-1:0]                    req_ready,
    output logic                                out_valid,
    output logic [RANGE_WIDTH-1:0]              FL,
    output logic [RANGE_WIDTH-1:0]              FH,
    output logic [SYMBOL_WIDTH-1:0]             SYMBOL,
    output logic [SYMBOL_WIDTH:0]               NSYMS,
    output logic                                bool,
    input  logic                                pipe_stall,
    output logic                                pipe_flush,
    input  logic                                flush_ack,
    output logic [ID_WIDTH-1:0]                 owner_id,
    output logic                                busy,
    output logic                                err
);

    localparam int                    CNT_WIDTH  = clog2(PIPE_DEPTH + 1);
    localparam logic [CNT_WIDTH-1:0]  DRAIN_LAST = CNT_WIDTH'(PIPE_DEPTH - 1);
    localparam logic [ID_WIDTH-1:0]   LAST_ID    = ID_WIDTH'(N_REQ - 1);

    state_t                  state;
    state_t                  state_next;
    logic [ID_WIDTH-1:0]     rr_ptr;
    logic [CNT_WIDTH-1:0]    drain_cnt;
    logic [N_REQ-1:0]        grant;
    logic [ID_WIDTH-1:0]     grant_idx;
    logic                    any_req;
    logic                    accept;
    logic                    beat_bad;

    logic [RANGE_WIDTH-1:0]  sel_fl;
    logic [RANGE_WIDTH-1:0]  sel_fh;
    logic [SYMBOL_WIDTH-1:0] sel_symbol;
    logic [SYMBOL_WIDTH:0]   sel_nsyms;
    logic                    sel_bool;
    logic                    sel_last;

    rr_arbiter #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign any_req = |grant;
    assign busy    = (state != IDLE);

    // Operand mux: only the owner's lanes ever reach stage_1.
    assign sel_fl     = req_fl[int'(owner_id)*RANGE_WIDTH +: RANGE_WIDTH];
    assign sel_fh     = req_fh[int'(owner_id)*RANGE_WIDTH +: RANGE_WIDTH];
    assign sel_symbol = req_symbol[int'(owner_id)*SYMBOL_WIDTH +: SYMBOL_WIDTH];
    assign sel_nsyms  = req_nsyms[int'(owner_id)*(SYMBOL_WIDTH+1) +: (SYMBOL_WIDTH+1)];
    assign sel_bool   = req_bool[owner_id];
    assign sel_last   = req_last[owner_id];

    always_comb begin
        state_next = state;
        req_ready  = '0;
        pipe_flush = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                req_ready[owner_id] = ~pipe_stall;
                accept              = req_valid[owner_id] & ~pipe_stall;
                if (accept && sel_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!pipe_stall && drain_cnt == DRAIN_LAST) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // The flush command must not be lost in a frozen cycle.
                if (!pipe_stall) begin
                    pipe_flush = 1'b1;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (flush_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_scheduler) begin
        if (!reset) begin
            state     <= IDLE;
            owner_id  <= '0;
            rr_ptr    <= '0;
            drain_cnt <= '0;
            out_valid <= 1'b0;
            FL        <= '0;
            FH        <= '0;
            SYMBOL    <= '0;
            NSYMS     <= '0;
            bool      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates, so every register samples pre-edge values regardless of statement order.
            state <= state_next;
            if (state == IDLE && any_req) begin
                owner_id <= grant_idx;
            end
            if (state == WAIT_ACK && flush_ack) begin
                rr_ptr <= (owner_id == LAST_ID) ? '0 : owner_id + 1'b1;
            end
            if (accept && sel_last) begin
                drain_cnt <= '0;
            end else if (state == DRAIN && !pipe_stall) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
            // A stalled pipeline freezes the issue register, including out_valid.
            if (accept) begin
                out_valid <= ~beat_bad;
                FL        <= sel_fl;
                FH        <= sel_fh;
                SYMBOL    <= sel_symbol;
                NSYMS     <= sel_nsyms;
                bool      <= sel_bool;
            end else if (!pipe_stall) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SCHED_PARAM_CHECK_EN
    localparam logic [SYMBOL_WIDTH:0] MAX_NSYMS = (SYMBOL_WIDTH+1)'(1 << SYMBOL_WIDTH);

    assign beat_bad = (sel_nsyms == '0) || (sel_nsyms > MAX_NSYMS) ||
                      (!sel_bool && ({1'b0, sel_symbol} >= sel_nsyms));

    always_ff @(posedge clk_scheduler) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (accept && beat_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign beat_bad = 1'b0;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_symbol_scheduler.sv
// Self-checking bench for symbol_scheduler: directed vector table, hand-written
// corner sequences, then random traffic against a stream-level reference model.
module tb_symbol_scheduler;

    localparam int N  = 2;
    localparam int IW = 1;
    localparam int RW = 16;
    localparam int SW = 4;
    localparam int PD = 4;

`ifdef SCHED_PARAM_CHECK_EN
    localparam logic C_OV  = 1'b0;
    localparam logic C_ERR = 1'b1;
`else
    localparam logic C_OV  = 1'b1;
    localparam logic C_ERR = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         req_valid, req_last, req_bool, req_ready;
    logic [N*RW-1:0]      req_fl, req_fh;
    logic [N*SW-1:0]      req_symbol;
    logic [N*(SW+1)-1:0]  req_nsyms;
    logic                 out_valid, bool_o, pipe_stall, pipe_flush, flush_ack, busy, err;
    logic [RW-1:0]        fl, fh;
    logic [SW-1:0]        symbol;
    logic [SW:0]          nsyms;
    logic [IW-1:0]        owner_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    symbol_scheduler #(
        .N_REQ(N), .ID_WIDTH(IW), .RANGE_WIDTH(RW), .SYMBOL_WIDTH(SW), .PIPE_DEPTH(PD)
    ) dut (
        .clk_scheduler(clk), .reset(reset),
        .req_valid(req_valid), .req_last(req_last), .req_fl(req_fl), .req_fh(req_fh),
        .req_symbol(req_symbol), .req_nsyms(req_nsyms), .req_bool(req_bool),
        .req_ready(req_ready), .out_valid(out_valid), .FL(fl), .FH(fh),
        .SYMBOL(symbol), .NSYMS(nsyms), .bool(bool_o), .pipe_stall(pipe_stall),
        .pipe_flush(pipe_flush), .flush_ack(flush_ack), .owner_id(owner_id),
        .busy(busy), .err(err)
    );

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic         stall;
        logic         ack;
        logic [N-1:0] ready;
        logic         flush;
        logic         ov;
        logic         busy;
        logic [IW-1:0] owner;
    } vec_t;

    vec_t tbl [25];

    logic [RW-1:0] c_fl [N];
    logic [RW-1:0] c_fh [N];
    logic [SW-1:0] c_sym [N];
    logic [SW:0]   c_ns [N];
    logic          c_bool [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic s, input logic a);
        @(negedge clk);
        req_valid  = v;
        req_last   = l;
        pipe_stall = s;
        flush_ack  = a;
        #1;
    endtask

    task automatic set_data(input int i, input logic [RW-1:0] f_l, input logic [RW-1:0] f_h,
                            input logic [SW-1:0] s, input logic [SW:0] ns, input logic b);
        req_fl[i*RW +: RW]             = f_l;
        req_fh[i*RW +: RW]             = f_h;
        req_symbol[i*SW +: SW]         = s;
        req_nsyms[i*(SW+1) +: (SW+1)]  = ns;
        req_bool[i]                    = b;
    endtask

    function automatic logic model_bad(input logic [SW:0] ns, input logic [SW-1:0] s, input logic b);
`ifdef SCHED_PARAM_CHECK_EN
        return (ns == 0) || (int'(ns) > (1 << SW)) || (!b && ({1'b0, s} >= ns));
`else
        return 1'b0 & ns[0] & s[0] & b;
`endif
    endfunction

    // Stream-level reference model state.
    logic          m_busy, m_have_last, m_flushed, m_ov, m_err, m_acc, m_bad;
    int            m_owner, m_rr, m_ns, flushes;
    logic [RW-1:0] m_fl, m_fh;
    logic [SW-1:0] m_sym;
    logic [SW:0]   m_nsyms;
    logic          m_bool;
    logic [N-1:0]  exp_ready;

    initial begin
        c_fl[0] = 16'h8000; c_fh[0] = 16'h7F00; c_sym[0] = 4'd2; c_ns[0] = 5'd4; c_bool[0] = 1'b0;
        c_fl[1] = 16'h1234; c_fh[1] = 16'h5678; c_sym[1] = 4'd1; c_ns[1] = 5'd3; c_bool[1] = 1'b1;

        //             valid  last  st ack  ready flush ov busy own
        tbl[0]  = '{2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0};
        tbl[1]  = '{2'b11, 2'b00, 0, 0, 2'b01, 0, 0, 1, 0};
        tbl[2]  = '{2'b11, 2'b00, 0, 1, 2'b01, 0, 1, 1, 0};
        tbl[3]  = '{2'b11, 2'b01, 0, 0, 2'b01, 0, 1, 1, 0};
        tbl[4]  = '{2'b10, 2'b00, 0, 0, 2'b00, 0, 1, 1, 0};
        tbl[5]  = '{2'b10, 2'b00, 0, 1, 2'b00, 0, 0, 1, 0};
        tbl[6]  = '{2'b10, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0};
        tbl[7]  = '{2'b10, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0};
        tbl[8]  = '{2'b10, 2'b00, 0, 0, 2'b00, 1, 0, 1, 0};
        tbl[9]  = '{2'b10, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0};
        tbl[10] = '{2'b11, 2'b00, 0, 1, 2'b00, 0, 0, 1, 0};
        tbl[11] = '{2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0};
        tbl[12] = '{2'b11, 2'b10, 0, 0, 2'b10, 0, 0, 1, 1};
        tbl[13] = '{2'b01, 2'b00, 1, 0, 2'b00, 0, 1, 1, 1};
        tbl[14] = '{2'b01, 2'b00, 1, 0, 2'b00, 0, 1, 1, 1};
        tbl[15] = '{2'b01, 2'b00, 0, 0, 2'b00, 0, 1, 1, 1};
        tbl[16] = '{2'b01, 2'b00, 0, 0, 2'b00, 0, 0, 1, 1};
        tbl[17] = '{2'b01, 2'b00, 0, 0, 2'b00, 0, 0, 1, 1};
        tbl[18] = '{2'b01, 2'b00, 0, 0, 2'b00, 0, 0, 1, 1};
        tbl[19] = '{2'b01, 2'b00, 1, 0, 2'b00, 0, 0, 1, 1};
        tbl[20] = '{2'b01, 2'b00, 0, 0, 2'b00, 1, 0, 1, 1};
        tbl[21] = '{2'b01, 2'b00, 0, 1, 2'b00, 0, 0, 1, 1};
        tbl[22] = '{2'b01, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1};
        tbl[23] = '{2'b01, 2'b00, 1, 0, 2'b00, 0, 0, 1, 0};
        tbl[24] = '{2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 1, 0};

        reset = 1'b0; req_valid = '0; req_last = '0; pipe_stall = 1'b0; flush_ack = 1'b0;
        req_fl = '0; req_fh = '0; req_symbol = '0; req_nsyms = '0; req_bool = '0;
        for (int i = 0; i < N; i++) set_data(i, c_fl[i], c_fh[i], c_sym[i], c_ns[i], c_bool[i]);
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner_id, 0);
        check("rst_err", err, 0);
        check("rst_flush", pipe_flush, 0);
        check("rst_ready", req_ready, 0);
        check("rst_fl", fl, 0);
        reset = 1'b1;

        // Directed vector table: two streams, round robin, stalls in DRAIN/FLUSH/RUN.
        for (int i = 0; i < 25; i++) begin
            step(tbl[i].valid, tbl[i].last, tbl[i].stall, tbl[i].ack);
            check($sformatf("tbl%0d_ready", i), req_ready, tbl[i].ready);
            check($sformatf("tbl%0d_flush", i), pipe_flush, tbl[i].flush);
            check($sformatf("tbl%0d_ov", i), out_valid, tbl[i].ov);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            check($sformatf("tbl%0d_owner", i), owner_id, tbl[i].owner);
            if (tbl[i].ov) begin
                check($sformatf("tbl%0d_fl", i), fl, c_fl[tbl[i].owner]);
                check($sformatf("tbl%0d_fh", i), fh, c_fh[tbl[i].owner]);
                check($sformatf("tbl%0d_sym", i), symbol, c_sym[tbl[i].owner]);
                check($sformatf("tbl%0d_nsyms", i), nsyms, c_ns[tbl[i].owner]);
                check($sformatf("tbl%0d_bool", i), bool_o, c_bool[tbl[i].owner]);
            end
        end

        // flush_ack withheld for 10 cycles in WAIT_ACK: owner kept, no new grant.
        step(2'b01, 2'b01, 0, 0);
        check("ack_last_ready", req_ready, 2'b01);
        flushes = 0;
        for (int k = 0; k < 15; k++) begin
            step(2'b11, 2'b00, 0, 0);
            if (k == 0) check("ack_last_issued", out_valid, 1);
            check("ack_busy", busy, 1);
            check("ack_owner", owner_id, 0);
            check("ack_ready", req_ready, 2'b00);
            flushes += int'(pipe_flush);
        end
        check("ack_flush_count", flushes, 1);
        step(2'b11, 2'b00, 0, 1);
        check("ack_wait_busy", busy, 1);
        step(2'b11, 2'b10, 0, 0);
        check("ack_idle_busy", busy, 0);

        // Reset during DRAIN abandons the stream without a flush.
        step(2'b11, 2'b10, 0, 0);
        check("rr_owner1", owner_id, 1);
        check("rr_ready1", req_ready, 2'b10);
        step(2'b00, 2'b00, 0, 0);
        step(2'b00, 2'b00, 0, 0);
        reset = 1'b0;
        step(2'b00, 2'b00, 0, 0);
        check("mrst_ov", out_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_owner", owner_id, 0);
        check("mrst_flush", pipe_flush, 0);
        reset = 1'b1;
        flushes = 0;
        for (int k = 0; k < 8; k++) begin
            step(2'b00, 2'b00, 0, 0);
            flushes += int'(pipe_flush) + int'(busy);
        end
        check("mrst_quiet", flushes, 0);
        step(2'b11, 2'b00, 0, 0);

        // Out-of-range beat: dropped and flagged when checking is built in.
        set_data(0, 16'hABCD, 16'h0100, 4'd5, 5'd3, 1'b0);
        step(2'b01, 2'b01, 0, 0);
        check("par_owner_after_rst", owner_id, 0);
        check("par_ready", req_ready, 2'b01);
        step(2'b00, 2'b00, 0, 0);
        check("par_ov", out_valid, C_OV);
        check("par_err", err, C_ERR);
        flushes = 0;
        for (int k = 0; k < 8; k++) begin
            step(2'b00, 2'b00, 0, 0);
            flushes += int'(pipe_flush);
        end
        check("par_flush_count", flushes, 1);
        step(2'b00, 2'b00, 0, 1);
        step(2'b00, 2'b00, 0, 0);
        check("par_err_sticky", err, C_ERR);
        check("par_idle", busy, 0);

        // Random traffic against the reference model.
        reset = 1'b0;
        step(2'b00, 2'b00, 0, 0);
        step(2'b00, 2'b00, 0, 0);
        reset = 1'b1;
        m_busy = 0; m_have_last = 0; m_flushed = 0; m_ov = 0; m_err = 0;
        m_owner = 0; m_rr = 0; m_ns = 0;
        m_fl = '0; m_fh = '0; m_sym = '0; m_nsyms = '0; m_bool = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check("rnd_out_valid", out_valid, m_ov);
            if (m_ov) begin
                check("rnd_fl", fl, m_fl);
                check("rnd_fh", fh, m_fh);
                check("rnd_sym", symbol, m_sym);
                check("rnd_nsyms", nsyms, m_nsyms);
                check("rnd_bool", bool_o, m_bool);
            end
            check("rnd_busy", busy, m_busy);
            if (m_busy) check("rnd_owner", owner_id, m_owner);
            check("rnd_err", err, m_err);

            for (int i = 0; i < N; i++) begin
                set_data(i, RW'($urandom), RW'($urandom), SW'($urandom),
                         (SW+1)'($urandom_range(0, 31)), 1'($urandom));
                req_valid[i] = ($urandom_range(0, 3) != 0);
                req_last[i]  = ($urandom_range(0, 3) == 0);
            end
            pipe_stall = ($urandom_range(0, 4) == 0);
            flush_ack  = ($urandom_range(0, 2) == 0);
            #1;

            exp_ready = '0;
            if (m_busy && !m_have_last && !pipe_stall) exp_ready[m_owner] = 1'b1;
            check("rnd_ready", req_ready, exp_ready);
            check("rnd_flush", pipe_flush, m_busy && m_have_last && !m_flushed && m_ns == PD && !pipe_stall);

            m_acc = m_busy && !m_have_last && !pipe_stall && req_valid[m_owner];
            if (m_acc) begin
                m_fl    = req_fl[m_owner*RW +: RW];
                m_fh    = req_fh[m_owner*RW +: RW];
                m_sym   = req_symbol[m_owner*SW +: SW];
                m_nsyms = req_nsyms[m_owner*(SW+1) +: (SW+1)];
                m_bool  = req_bool[m_owner];
                m_bad   = model_bad(m_nsyms, m_sym, m_bool);
                m_ov    = !m_bad;
                if (m_bad) m_err = 1'b1;
            end else if (!pipe_stall) begin
                m_ov = 1'b0;
            end
            if (!m_busy) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req_valid[(m_rr + k) % N]) begin
                        m_busy  = 1'b1;
                        m_owner = (m_rr + k) % N;
                    end
                end
                m_have_last = 1'b0;
            end else if (!m_have_last) begin
                if (m_acc && req_last[m_owner]) begin
                    m_have_last = 1'b1;
                    m_ns        = 0;
                    m_flushed   = 1'b0;
                end
            end else if (!m_flushed) begin
                if (!pipe_stall) begin
                    if (m_ns == PD) m_flushed = 1'b1;
                    else m_ns++;
                end
            end else if (flush_ack) begin
                m_busy = 1'b0;
                m_rr   = (m_owner + 1) % N;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
